// File: rtl/rule_scheduler.sv
// Picks one enabled guarded rule per cycle for the Murphi `system` block, round-robin or LFSR-seeded,
// counting fires against a step budget and flagging deadlock when no guard holds.
module rule_scheduler #(
   parameter int NUM_RULES = 12,
   parameter int SEL_W     = 4,
   parameter int IDLE_CODE = 15,
   parameter int CNT_W     = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NUM_RULES-1:0] io_guards,
   input  logic                 io_start,
   input  logic                 io_stop,
   input  logic                 io_mode,
   input  logic [7:0]           io_seed,
   input  logic [CNT_W-1:0]     io_max_steps,
   output logic [SEL_W-1:0]     io_en_a,
   output logic                 io_fire,
   output logic [1:0]           io_state,
   output logic                 io_deadlock,
   output logic                 io_done,
   output logic [CNT_W-1:0]     io_fire_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      STALL = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             state, state_nxt;
   logic               mode, mode_nxt;
   logic [SEL_W-1:0]   ptr, ptr_nxt;
   logic [7:0]         lfsr, lfsr_nxt;
   logic [CNT_W-1:0]   budget, budget_nxt;
   logic [CNT_W-1:0]   fire_cnt, fire_cnt_nxt;
   logic               deadlock, deadlock_nxt;

   logic [SEL_W-1:0]   start_idx;
   logic [SEL_W-1:0]   sel;
   logic [SEL_W:0]     cand;
   logic               any_guard;
   logic               accept;

   // Cyclic priority search; walking k downwards lets the smallest offset win without a found flag.
   always_comb begin
      start_idx = mode ? lfsr[SEL_W-1:0] : ptr;
      if (mode && (start_idx >= SEL_W'(NUM_RULES)))
         start_idx = start_idx - SEL_W'(NUM_RULES);
      sel       = '0;
      any_guard = 1'b0;
      cand      = '0;
      for (int k = NUM_RULES - 1; k >= 0; k--) begin
         cand = {1'b0, start_idx} + (SEL_W+1)'(k);
         if (cand >= (SEL_W+1)'(NUM_RULES))
            cand = cand - (SEL_W+1)'(NUM_RULES);
         if (io_guards[cand[SEL_W-1:0]]) begin
            sel       = cand[SEL_W-1:0];
            any_guard = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      mode_nxt     = mode;
      ptr_nxt      = ptr;
      lfsr_nxt     = lfsr;
      budget_nxt   = budget;
      fire_cnt_nxt = fire_cnt;
      deadlock_nxt = deadlock;
      io_fire      = 1'b0;
      io_en_a      = SEL_W'(IDLE_CODE);
      accept       = 1'b0;

      case (state)
         IDLE: begin
            if (io_start)
               accept = 1'b1;
         end
         RUN: begin
            // Taps 8,6,5,4 feed bit 0; steps every RUN cycle whether or not a rule fires.
            lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            if (io_stop) begin
               state_nxt = IDLE;
            end else if (!any_guard) begin
               state_nxt    = STALL;
               deadlock_nxt = 1'b1;
            end else begin
               io_fire      = 1'b1;
               io_en_a      = sel;
               ptr_nxt      = (sel == SEL_W'(NUM_RULES - 1)) ? '0 : sel + 1'b1;
               budget_nxt   = budget - 1'b1;
               fire_cnt_nxt = (&fire_cnt) ? fire_cnt : fire_cnt + 1'b1;
               if (budget == CNT_W'(1))
                  state_nxt = DONE;
            end
         end
         STALL: begin
            if (io_stop)
               state_nxt = IDLE;
         end
         DONE: begin
            if (io_stop)
               state_nxt = IDLE;
            else if (io_start)
               accept = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase

      if (accept) begin
         mode_nxt     = io_mode;
         lfsr_nxt     = (io_seed == 8'h00) ? 8'h01 : io_seed;
         budget_nxt   = io_max_steps;
         ptr_nxt      = '0;
         fire_cnt_nxt = '0;
         deadlock_nxt = 1'b0;
         state_nxt    = (io_max_steps == '0) ? DONE : RUN;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         mode     <= 1'b0;
         ptr      <= '0;
         lfsr     <= 8'h01;
         budget   <= '0;
         fire_cnt <= '0;
         deadlock <= 1'b0;
      end else begin
         state    <= state_nxt;
         mode     <= mode_nxt;
         ptr      <= ptr_nxt;
         lfsr     <= lfsr_nxt;
         budget   <= budget_nxt;
         fire_cnt <= fire_cnt_nxt;
         deadlock <= deadlock_nxt;
      end
   end

   assign io_state      = state;
   assign io_done       = (state == DONE);
   assign io_deadlock   = deadlock;
   assign io_fire_count = fire_cnt;

endmodule

// File: tb/tb_rule_scheduler.sv
// Directed bench for rule_scheduler: an integer-level scheduler model checked every cycle,
// plus hand-computed literal expectations for the main scenarios.
module tb_rule_scheduler;
   localparam int N = 12;

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] guards;
   logic        start, stop, mode;
   logic [7:0]  seed;
   logic [15:0] max_steps;
   logic [3:0]  en_a;
   logic        fire, deadlock, done;
   logic [1:0]  state;
   logic [15:0] fire_count;

   always #5 clk = ~clk;

   rule_scheduler dut (
      .clock(clk), .reset(reset), .io_guards(guards), .io_start(start), .io_stop(stop),
      .io_mode(mode), .io_seed(seed), .io_max_steps(max_steps), .io_en_a(en_a),
      .io_fire(fire), .io_state(state), .io_deadlock(deadlock), .io_done(done),
      .io_fire_count(fire_count)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Model: states 0 idle, 1 run, 2 stall, 3 done.
   int  m_st, m_ptr, m_lf, m_bud, m_cnt, m_sel;
   bit  m_dl, m_md;
   bit  model_on = 1'b0;

   function automatic int model_sel();
      int s;
      s = m_md ? (m_lf % 16) % N : m_ptr;
      for (int k = 0; k < N; k++)
         if (guards[(s + k) % N]) return (s + k) % N;
      return -1;
   endfunction

   task automatic model_start();
      m_md  = mode;
      m_lf  = (seed == 0) ? 1 : int'(seed);
      m_bud = int'(max_steps);
      m_ptr = 0;
      m_cnt = 0;
      m_dl  = 1'b0;
      m_st  = (max_steps == 0) ? 3 : 1;
   endtask

   always @(posedge clk) begin
      m_sel = model_sel();
      if (reset) begin
         m_st = 0; m_ptr = 0; m_lf = 1; m_bud = 0; m_cnt = 0; m_dl = 1'b0; m_md = 1'b0;
         model_on = 1'b1;
      end else begin
         case (m_st)
            0: if (start) model_start();
            1: begin
               m_lf = ((m_lf << 1) | (((m_lf >> 7) ^ (m_lf >> 5) ^ (m_lf >> 4) ^ (m_lf >> 3)) & 1)) & 255;
               if (stop) m_st = 0;
               else if (m_sel < 0) begin m_st = 2; m_dl = 1'b1; end
               else begin
                  m_ptr = (m_sel + 1) % N;
                  m_cnt = (m_cnt == 65535) ? 65535 : m_cnt + 1;
                  if (m_bud == 1) m_st = 3;
                  m_bud = m_bud - 1;
               end
            end
            2: if (stop) m_st = 0;
            default: if (stop) m_st = 0; else if (start) model_start();
         endcase
      end
   end

   always @(negedge clk) begin
      int  s;
      bit  ef;
      int  ee;
      if (model_on) begin
         s  = model_sel();
         ef = (m_st == 1) && !stop && (s >= 0);
         ee = ef ? s : 15;
         tests++;
         if (int'(en_a) != ee || fire != ef || int'(state) != m_st || deadlock != m_dl ||
             done != (m_st == 3) || int'(fire_count) != m_cnt) begin
            fails++;
            $display("FAIL model t=%0t: en_a=%0d/%0d fire=%0d/%0d state=%0d/%0d dl=%0d/%0d done=%0d cnt=%0d/%0d (got/expected)",
                     $time, en_a, ee, fire, ef, state, m_st, deadlock, m_dl, done, fire_count, m_cnt);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   int exp_seq [6] = '{1, 2, 4, 8, 1, 3};
   logic [11:0] pat [8] = '{12'h001, 12'h800, 12'h0F0, 12'h421, 12'h924, 12'h003, 12'hC00, 12'h555};

   initial begin
      reset = 1'b1; guards = '0; start = 1'b0; stop = 1'b0; mode = 1'b0; seed = '0; max_steps = '0;
      repeat (2) cyc();
      reset = 1'b0;

      // Idle after reset
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("idle_en_a", en_a, 15);
         check("idle_fire", fire, 0);
         check("idle_state", state, 0);
         cyc();
      end
      check("idle_count", fire_count, 0);

      // Round-robin, all guards, budget 5
      guards = 12'hFFF; max_steps = 5; start = 1'b1;
      cyc(); start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("rr_en_a", en_a, i);
         cyc();
      end
      @(negedge clk);
      check("rr_done_state", state, 3);
      check("rr_done_flag", done, 1);
      check("rr_count", fire_count, 5);

      // Pointer wrap with sparse guards
      max_steps = 100; start = 1'b1;
      cyc(); start = 1'b0;
      repeat (3) cyc();
      guards = 12'b1000_0000_0100;
      @(negedge clk); check("wrap_first", en_a, 11);
      cyc(); @(negedge clk); check("wrap_second", en_a, 2);
      cyc(); @(negedge clk); check("wrap_third", en_a, 11);
      cyc(); stop = 1'b1;
      @(negedge clk); check("stop_no_fire", fire, 0);
      cyc(); stop = 1'b0;
      @(negedge clk);
      check("stop_idle", state, 0);
      check("stop_count", fire_count, 6);

      // Deadlock
      guards = '0; max_steps = 10; start = 1'b1;
      cyc(); start = 1'b0;
      cyc();
      @(negedge clk);
      check("dl_state", state, 2);
      check("dl_flag", deadlock, 1);
      check("dl_en_a", en_a, 15);
      guards = 12'hFFF;
      cyc(); @(negedge clk); check("dl_hold_guards", state, 2);
      start = 1'b1; cyc(); start = 1'b0;
      @(negedge clk); check("dl_ignore_start", state, 2);
      stop = 1'b1; cyc(); stop = 1'b0;
      @(negedge clk);
      check("dl_stop_idle", state, 0);
      check("dl_sticky", deadlock, 1);

      // Zero budget
      max_steps = 0; start = 1'b1;
      cyc(); start = 1'b0;
      @(negedge clk);
      check("zero_state", state, 3);
      check("zero_count", fire_count, 0);
      check("zero_dl_clear", deadlock, 0);

      // LFSR mode: seed 0 and seed 1 give the same sequence (restart from DONE)
      mode = 1'b1; guards = 12'hFFF; max_steps = 6;
      for (int r = 0; r < 2; r++) begin
         seed = 8'(r); start = 1'b1;
         cyc(); start = 1'b0;
         for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check(r == 0 ? "lfsr_seed0" : "lfsr_seed1", en_a, exp_seq[i]);
            cyc();
         end
      end
      @(negedge clk); check("lfsr_done", state, 3);
      start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
      @(negedge clk); check("done_stop_wins", state, 0);

      // LFSR mode with varying guards; model tracks each pick
      seed = 8'hA5; max_steps = 20; start = 1'b1;
      cyc(); start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         guards = pat[i % 8];
         cyc();
      end
      @(negedge clk);
      check("rand_state", state, 3);
      check("rand_count", fire_count, 20);

      // Reset mid-run after three fires
      mode = 1'b0; guards = 12'hFFF; max_steps = 50; start = 1'b1;
      cyc(); start = 1'b0;
      repeat (3) cyc();
      reset = 1'b1; cyc(); reset = 1'b0;
      @(negedge clk);
      check("rst_state", state, 0);
      check("rst_count", fire_count, 0);
      check("rst_en_a", en_a, 15);
      cyc();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
